// File: rtl/audio_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | audio_pkg                                                            |
// | Shared constants and state encoding for the audio capture path.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package audio_pkg;

    localparam int c_DATA_BITS = 16;
    localparam int c_FRAME_LEN = 1024;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_FULL    = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/audio_frame_capture_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | audio_frame_capture_ctrl_if                                          |
// | I2S, frame RAM and FFT handshake signals of the capture controller.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface audio_frame_capture_ctrl_if #(
    parameter int DATA_BITS  = 16,
    parameter int ADDR_BITS  = 10,
    parameter int DECIM_BITS = 4
);
    logic                  enable_i;
    logic                  i2s_get_o;
    logic                  i2s_done_i;
    logic [DATA_BITS-1:0]  i2s_sample_data_L_i;
    logic [DATA_BITS-1:0]  i2s_sample_data_R_i;
    logic [DECIM_BITS-1:0] decim_i;
    logic                  buf_we_o;
    logic [ADDR_BITS-1:0]  buf_addr_o;
    logic [DATA_BITS-1:0]  buf_wdata_o;
    logic                  frame_ready_o;
    logic                  frame_ack_i;
    logic                  overrun_o;
    logic                  busy_o;

    // Controller side.
    modport slave (
        input  enable_i, i2s_done_i, i2s_sample_data_L_i, i2s_sample_data_R_i,
               decim_i, frame_ack_i,
        output i2s_get_o, buf_we_o, buf_addr_o, buf_wdata_o, frame_ready_o,
               overrun_o, busy_o
    );

    // Environment side (receiver, RAM, FFT).
    modport master (
        output enable_i, i2s_done_i, i2s_sample_data_L_i, i2s_sample_data_R_i,
               decim_i, frame_ack_i,
        input  i2s_get_o, buf_we_o, buf_addr_o, buf_wdata_o, frame_ready_o,
               overrun_o, busy_o
    );
endinterface
`default_nettype wire

// File: rtl/pulse_sync_edge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pulse_sync_edge                                                      |
// | 2-FF synchronizer plus rising-edge detector; 1-cycle output pulse.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module pulse_sync_edge (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_async,
    output logic      o_pulse
);
    logic r_sync1;
    logic r_sync2;
    logic r_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= i_async;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign o_pulse = r_sync2 & ~r_prev;
endmodule
`default_nettype wire

// File: rtl/audio_frame_capture_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | audio_frame_capture_ctrl                                             |
// | Fills an FFT frame buffer from the I2S receiver with optional        |
// | decimation. Build option AUDIO_MONO_MIX_EN stores (L+R)/2 instead   |
// | of the left channel.                                                 |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module audio_frame_capture_ctrl
    import audio_pkg::*;
#(
    parameter int DATA_BITS  = c_DATA_BITS,
    parameter int FRAME_LEN  = c_FRAME_LEN,
    parameter int ADDR_BITS  = $clog2(FRAME_LEN),
    parameter int DECIM_BITS = 4
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    audio_frame_capture_ctrl_if.slave bus
);
    localparam logic [ADDR_BITS-1:0] c_LAST_ADDR = ADDR_BITS'(FRAME_LEN - 1);

    logic                  w_sample_evt;
    logic [DATA_BITS-1:0]  w_sample;

    state_t                r_state;
    logic [ADDR_BITS-1:0]  r_addr;
    logic [DECIM_BITS-1:0] r_decim;
    logic [DECIM_BITS-1:0] r_dcnt;
    logic                  r_wrap;
    logic                  r_we;
    logic [ADDR_BITS-1:0]  r_baddr;
    logic [DATA_BITS-1:0]  r_wdata;
    logic                  r_get;
    logic                  r_ready;
    logic                  r_overrun;

    pulse_sync_edge u_done_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (bus.i2s_done_i),
        .o_pulse (w_sample_evt)
    );

`ifdef AUDIO_MONO_MIX_EN
    logic [DATA_BITS:0] w_mix_sum;
    assign w_mix_sum = {bus.i2s_sample_data_L_i[DATA_BITS-1], bus.i2s_sample_data_L_i}
                     + {bus.i2s_sample_data_R_i[DATA_BITS-1], bus.i2s_sample_data_R_i};
    // Dropping the LSB of the widened sum is an arithmetic shift (floor).
    assign w_sample  = w_mix_sum[DATA_BITS:1];
`else
    assign w_sample  = bus.i2s_sample_data_L_i;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_addr    <= '0;
            r_decim   <= '0;
            r_dcnt    <= '0;
            r_wrap    <= 1'b0;
            r_we      <= 1'b0;
            r_baddr   <= '0;
            r_wdata   <= '0;
            r_get     <= 1'b0;
            r_ready   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_we   <= 1'b0;
            r_wrap <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.enable_i) begin
                        r_state   <= ST_CAPTURE;
                        r_get     <= 1'b1;
                        r_addr    <= '0;
                        r_decim   <= bus.decim_i;
                        r_dcnt    <= '0;
                        r_overrun <= 1'b0;
                    end
                end
                ST_CAPTURE: begin
                    if (!bus.enable_i) begin
                        r_state <= ST_IDLE;
                        r_get   <= 1'b0;
                        r_addr  <= '0;
                        r_dcnt  <= '0;
                    end else if (r_wrap) begin
                        // Frame becomes visible one cycle after its last strobe.
                        r_state <= ST_FULL;
                        r_ready <= 1'b1;
                    end else if (w_sample_evt) begin
                        if (r_dcnt == '0) begin
                            r_we    <= 1'b1;
                            r_baddr <= r_addr;
                            r_wdata <= w_sample;
                            r_addr  <= r_addr + 1'b1;
                            r_wrap  <= (r_addr == c_LAST_ADDR);
                        end
                        r_dcnt <= (r_dcnt == r_decim) ? '0 : r_dcnt + 1'b1;
                    end
                end
                ST_FULL: begin
                    if (bus.frame_ack_i) begin
                        r_ready <= 1'b0;
                        r_dcnt  <= '0;
                        if (bus.enable_i) begin
                            r_state <= ST_CAPTURE;
                            r_decim <= bus.decim_i;
                        end else begin
                            r_state <= ST_IDLE;
                            r_get   <= 1'b0;
                        end
                    end else if (w_sample_evt) begin
                        r_overrun <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.i2s_get_o     = r_get;
    assign bus.buf_we_o      = r_we;
    assign bus.buf_addr_o    = r_baddr;
    assign bus.buf_wdata_o   = r_wdata;
    assign bus.frame_ready_o = r_ready;
    assign bus.overrun_o     = r_overrun;
    assign bus.busy_o        = (r_state != ST_IDLE);
endmodule
`default_nettype wire

// File: tb/tb_audio_frame_capture_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_audio_frame_capture_ctrl                                          |
// | Directed/random bench with a sample-index reference model.           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_audio_frame_capture_ctrl;
    localparam int c_DW = 16;
    localparam int c_FL = 1024;
    localparam int c_AW = 10;
    localparam int c_DCW = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    audio_frame_capture_ctrl_if #(.DATA_BITS(c_DW), .ADDR_BITS(c_AW), .DECIM_BITS(c_DCW)) bus ();

    audio_frame_capture_ctrl #(
        .DATA_BITS(c_DW), .FRAME_LEN(c_FL), .ADDR_BITS(c_AW), .DECIM_BITS(c_DCW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: frame position as sample/write counts.
    int          exp_addr[$];
    logic [15:0] exp_data[$];
    bit          m_active, m_full, m_overrun;
    int          m_k, m_w, m_d;
    bit          r_last_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [15:0] ref_word(input logic [15:0] l, input logic [15:0] r);
`ifdef AUDIO_MONO_MIX_EN
        int s;
        s = int'($signed(l)) + int'($signed(r));
        return 16'(s >>> 1);
`else
        return (r === r) ? l : l;
`endif
    endfunction

    task automatic model_start(input int d);
        m_active = 1; m_full = 0; m_k = 0; m_w = 0; m_d = d; m_overrun = 0;
    endtask

    task automatic model_ack(input int d);
        m_full = 0; m_k = 0; m_w = 0; m_d = d;
    endtask

    task automatic model_sample(input logic [15:0] l, input logic [15:0] r);
        if (m_full) m_overrun = 1;
        else if (m_active) begin
            if (m_k % (m_d + 1) == 0) begin
                exp_addr.push_back(m_w);
                exp_data.push_back(ref_word(l, r));
                m_w++;
                if (m_w == c_FL) begin m_full = 1; m_w = 0; end
            end
            m_k++;
        end
    endtask

    task automatic send(input logic [15:0] l, input logic [15:0] r);
        @(posedge clk); #1;
        bus.i2s_sample_data_L_i = l;
        bus.i2s_sample_data_R_i = r;
        bus.i2s_done_i = 1'b1;
        model_sample(l, r);
        repeat (3) @(posedge clk);
        #1 bus.i2s_done_i = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    // Write-strobe monitor against the expected-write queue.
    always @(negedge clk) begin
        if (r_last_seen) chk("ready_after_last", bus.frame_ready_o, 1);
        r_last_seen = 0;
        if (bus.buf_we_o === 1'b1) begin
            if (exp_addr.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_strobe: observed addr %0d, expected no write", bus.buf_addr_o);
            end else begin
                chk("wr_addr", bus.buf_addr_o, exp_addr[0]);
                chk("wr_data", bus.buf_wdata_o, exp_data[0]);
                chk("ready_during_strobe", bus.frame_ready_o, 0);
                if (exp_addr[0] == c_FL - 1) r_last_seen = 1;
                void'(exp_addr.pop_front());
                void'(exp_data.pop_front());
            end
        end
    end

    initial begin
        bus.enable_i = 0; bus.i2s_done_i = 0; bus.i2s_sample_data_L_i = '0;
        bus.i2s_sample_data_R_i = '0; bus.decim_i = '0; bus.frame_ack_i = 0;
        m_active = 0; m_full = 0; m_overrun = 0; r_last_seen = 0;
        rst = 1;
        repeat (3) @(posedge clk); #1;
        chk("rst_get", bus.i2s_get_o, 0);
        chk("rst_we", bus.buf_we_o, 0);
        chk("rst_addr", bus.buf_addr_o, 0);
        chk("rst_wdata", bus.buf_wdata_o, 0);
        chk("rst_ready", bus.frame_ready_o, 0);
        chk("rst_overrun", bus.overrun_o, 0);
        chk("rst_busy", bus.busy_o, 0);
        rst = 0;

        // Full frame, no decimation, L = n.
        step(); bus.enable_i = 1; bus.decim_i = 0; model_start(0);
        step();
        chk("en_get", bus.i2s_get_o, 1);
        chk("en_busy", bus.busy_o, 1);
        for (int n = 0; n < c_FL; n++) send(16'(n), 16'($urandom));
        chk("f1_ready", bus.frame_ready_o, 1);
        chk("f1_get", bus.i2s_get_o, 1);
        chk("f1_drained", exp_addr.size(), 0);

        // Samples while frame held -> overrun, no writes.
        send(16'($urandom), 16'($urandom));
        send(16'($urandom), 16'($urandom));
        chk("ovr_set", bus.overrun_o, m_overrun);
        chk("ovr_ready", bus.frame_ready_o, 1);

        // Ack with decim 3 re-latched: keep samples 0,4,8,12.
        bus.decim_i = 3;
        step(); bus.frame_ack_i = 1;
        step(); bus.frame_ack_i = 0; model_ack(3);
        chk("ack_ready_drop", bus.frame_ready_o, 0);
        for (int n = 0; n < 16; n++) send(16'($urandom), 16'($urandom));
        chk("decim_drained", exp_addr.size(), 0);
        chk("ovr_sticky", bus.overrun_o, m_overrun);

        // Abort to IDLE keeps overrun; re-enable clears it.
        bus.enable_i = 0; m_active = 0;
        step(); step();
        chk("abort_get", bus.i2s_get_o, 0);
        chk("abort_busy", bus.busy_o, 0);
        chk("abort_ovr", bus.overrun_o, 1);
        bus.enable_i = 1; bus.decim_i = 0; model_start(0);
        step(); step();
        chk("reen_ovr_clr", bus.overrun_o, 0);

        // Partial frame of 500 samples, then abort.
        send(16'h7FFF, 16'h7FFF);
        send(16'hFFFD, 16'h0000);
        for (int n = 2; n < 500; n++) send(16'($urandom), 16'($urandom));
        bus.enable_i = 0; m_active = 0;
        step(); step();
        chk("part_get", bus.i2s_get_o, 0);
        chk("part_busy", bus.busy_o, 0);
        chk("part_ready", bus.frame_ready_o, 0);
        chk("part_drained", exp_addr.size(), 0);

        // Re-enable: first write lands at addr 0; fill a frame.
        bus.enable_i = 1; model_start(0);
        step();
        for (int n = 0; n < c_FL; n++) send(16'($urandom), 16'($urandom));
        chk("f2_ready", bus.frame_ready_o, 1);

        // Ack coincident with sample_evt: sample silently dropped.
        step();
        bus.i2s_sample_data_L_i = 16'($urandom);
        bus.i2s_done_i = 1;
        @(posedge clk);
        step(); bus.frame_ack_i = 1;
        step(); bus.frame_ack_i = 0; model_ack(0);
        repeat (2) @(posedge clk);
        #1 bus.i2s_done_i = 0;
        repeat (4) @(posedge clk); #1;
        chk("coin_ovr", bus.overrun_o, 0);
        chk("coin_ready", bus.frame_ready_o, 0);
        chk("coin_busy", bus.busy_o, 1);
        send(16'($urandom), 16'($urandom));
        chk("coin_next_drained", exp_addr.size(), 0);

        // Reset mid-frame clears every output.
        for (int n = 0; n < 5; n++) send(16'($urandom), 16'($urandom));
        step(); rst = 1;
        step();
        chk("mid_rst_get", bus.i2s_get_o, 0);
        chk("mid_rst_we", bus.buf_we_o, 0);
        chk("mid_rst_addr", bus.buf_addr_o, 0);
        chk("mid_rst_wdata", bus.buf_wdata_o, 0);
        chk("mid_rst_busy", bus.busy_o, 0);
        chk("mid_rst_ready", bus.frame_ready_o, 0);
        bus.enable_i = 0; rst = 0;
        exp_addr.delete(); exp_data.delete();
        repeat (3) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
